// File: rtl/channel_cfg_sequencer_pkg.sv
// Shared types and constants for the channel configuration sequencer.
// Holds the FSM state enum, the attenuation-to-alpha table and beta helper.
package channel_cfg_pkg;

  localparam int COEF_W      = 16;
  localparam int ATT_ENTRIES = 8;
  localparam int AIDX_W      = $clog2(ATT_ENTRIES);

  typedef logic [COEF_W-1:0] coef_t;

  localparam coef_t Q1_15_ONE = 16'h8000;

  typedef enum logic [1:0] {
    RUN,
    ARM,
    FLUSH,
    LOAD
  } state_e;

  localparam coef_t ALPHA_TAB [ATT_ENTRIES] = '{
    16'h0000, 16'h1000, 16'h2000, 16'h3000,
    16'h4000, 16'h5000, 16'h6000, 16'h7000
  };

  // alpha never exceeds 0x7000, so the subtraction cannot wrap
  function automatic coef_t beta_of(coef_t a);
    return Q1_15_ONE - a;
  endfunction

endpackage

// File: rtl/channel_cfg_sequencer_if.sv
// Attenuation-change request channel (valid/ready plus reject pulse).
// Ports: cfg_valid/cfg_idx from requester; cfg_ready/cfg_err back to it.
interface channel_cfg_sequencer_if #(
  parameter int IDX_W = 3
);

  logic             cfg_valid;
  logic [IDX_W-1:0] cfg_idx;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_idx,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_idx,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/channel_cfg_sequencer_ui_counter.sv
// Free-running mod-N sample counter producing the UI boundary strobe.
// Ports: i_clk, i_rst (sync, active-high) in; o_strobe on the last sample.
module ui_counter #(
  parameter int N = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_strobe
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_strobe = (r_cnt == LAST) && !i_rst;

endmodule

// File: rtl/channel_cfg_sequencer.sv
// Sequences RX channel filter reconfiguration: UI timing, flush, coef load.
// Ports: CLK, rst; cfg request channel; filter enables/clear; alpha/beta.
module channel_cfg_sequencer
  import channel_cfg_pkg::*;
#(
  parameter int N           = 10,
  parameter int FLUSH_LEN   = 16,
  parameter int DEFAULT_IDX = 2,
  parameter int IDX_W       = 3
) (
  input  logic                    CLK,
  input  logic                    rst,
  channel_cfg_sequencer_if.slave  cfg,
  output logic                    sample_en,
  output logic                    ui_strobe,
  output logic                    filt_clr,
  output coef_t                   coef_alpha,
  output coef_t                   coef_beta,
  output logic                    coef_upd,
  output logic [AIDX_W-1:0]       att_idx,
  output logic                    busy
);

  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam logic [FW-1:0] FLAST = FW'(FLUSH_LEN - 1);
  localparam logic [AIDX_W-1:0] DEF = AIDX_W'(DEFAULT_IDX);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [FW-1:0]       r_fcnt;
  logic [AIDX_W-1:0]   r_pend;
  logic [AIDX_W-1:0]   r_idx;
  coef_t               r_alpha;
  logic                r_err;
  logic                w_strobe;
  logic                w_accept;
  logic                w_bad;

  ui_counter #(
    .N (N)
  ) u_ui (
    .i_clk    (CLK),
    .i_rst    (rst),
    .o_strobe (w_strobe)
  );

  // Only a request channel wider than the table can carry a bad index
  generate
    if (IDX_W > AIDX_W) begin : g_chk
      assign w_bad = (cfg.cfg_idx >= IDX_W'(ATT_ENTRIES));
    end else begin : g_nochk
      assign w_bad = 1'b0;
    end
  endgenerate

  assign w_accept = cfg.cfg_valid && cfg.cfg_ready;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= RUN;
      r_fcnt  <= '0;
      r_pend  <= DEF;
      r_idx   <= DEF;
      r_alpha <= ALPHA_TAB[DEFAULT_IDX];
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_accept && w_bad;
      if (w_accept && !w_bad) begin
        r_pend <= cfg.cfg_idx[AIDX_W-1:0];
      end
      if (r_state == FLUSH) begin
        r_fcnt <= r_fcnt + FW'(1);
      end else begin
        r_fcnt <= '0;
      end
      if (r_state == LOAD) begin
        r_alpha <= ALPHA_TAB[r_pend];
        r_idx   <= r_pend;
      end
    end
  end

  // ARM is entered the cycle after accept, so any strobe seen
  // in ARM is strictly later than the accept cycle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (w_accept && !w_bad) begin
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        if (w_strobe) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (r_fcnt == FLAST) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_comb begin
    sample_en     = 1'b0;
    filt_clr      = 1'b0;
    coef_upd      = 1'b0;
    busy          = 1'b0;
    cfg.cfg_ready = 1'b0;
    if (!rst) begin
      sample_en     = (r_state == RUN) || (r_state == ARM);
      filt_clr      = (r_state == FLUSH);
      coef_upd      = (r_state == LOAD);
      busy          = (r_state != RUN);
      cfg.cfg_ready = (r_state == RUN);
    end
  end

  assign cfg.cfg_err = r_err;
  assign ui_strobe   = w_strobe;
  assign coef_alpha  = r_alpha;
  assign coef_beta   = beta_of(r_alpha);
  assign att_idx     = r_idx;

endmodule

// File: tb/tb_channel_cfg_sequencer.sv
// Self-checking bench for channel_cfg_sequencer.
// Timeline reference model compared every cycle, plus directed checks.
module tb_channel_cfg_sequencer;
  import channel_cfg_pkg::*;

  logic        CLK = 1'b0;
  logic        rst;
  logic        sample_en;
  logic        ui_strobe;
  logic        filt_clr;
  coef_t       coef_alpha;
  coef_t       coef_beta;
  logic        coef_upd;
  logic [2:0]  att_idx;
  logic        busy;

  always #5 CLK = ~CLK;

  channel_cfg_sequencer_if #(.IDX_W(4)) bus ();

  channel_cfg_sequencer #(
    .N           (10),
    .FLUSH_LEN   (16),
    .DEFAULT_IDX (2),
    .IDX_W       (4)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .cfg        (bus),
    .sample_en  (sample_en),
    .ui_strobe  (ui_strobe),
    .filt_clr   (filt_clr),
    .coef_alpha (coef_alpha),
    .coef_beta  (coef_beta),
    .coef_upd   (coef_upd),
    .att_idx    (att_idx),
    .busy       (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // model: cycles since reset, applied index, pending change timeline
  int m_since;
  int m_idx;
  int m_pend;
  int m_t1;
  bit m_active;
  bit m_err;

  int clr_cnt;
  int upd_cnt;
  int clr_first;
  int rel;
  int t0c;
  int strobe_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(bit r, bit v, int idx);
    int ph;
    bit fl;
    bit ld;
    rst           = r;
    bus.cfg_valid = v;
    bus.cfg_idx   = 4'(idx);
    #1;
    ph = m_since % 10;
    fl = m_active && cyc > m_t1 && cyc <= m_t1 + 16;
    ld = m_active && cyc == m_t1 + 17;
    chk("sample_en", sample_en, !r && !fl && !ld);
    chk("cfg_ready", bus.cfg_ready, !r && !m_active);
    chk("busy", busy, !r && m_active);
    chk("filt_clr", filt_clr, !r && fl);
    chk("coef_upd", coef_upd, !r && ld);
    chk("ui_strobe", ui_strobe, !r && ph == 9);
    chk("cfg_err", bus.cfg_err, m_err);
    chk("coef_alpha", coef_alpha, m_idx * 4096);
    chk("coef_beta", coef_beta, 32768 - m_idx * 4096);
    chk("att_idx", att_idx, m_idx);
    if (filt_clr === 1'b1) begin
      clr_cnt++;
      if (clr_first < 0) clr_first = cyc;
    end
    if (coef_upd === 1'b1) upd_cnt++;
    if (ui_strobe === 1'b1) strobe_q.push_back(cyc - rel);
    if (r) begin
      m_since  = 0;
      m_idx    = 2;
      m_active = 0;
      m_err    = 0;
    end else begin
      m_err = 0;
      if (m_active) begin
        if (cyc == m_t1 + 17) begin
          m_active = 0;
          m_idx    = m_pend;
        end
      end else if (v) begin
        if (idx >= 8) begin
          m_err = 1;
        end else begin
          m_active = 1;
          m_pend   = idx;
          m_t1     = cyc + ((ph == 9) ? 10 : 9 - ph);
        end
      end
      m_since++;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic wait_free();
    for (int i = 0; i < 40 && m_active; i++) cycle(0, 0, 0);
  endtask

  task automatic wait_phase(int p);
    for (int i = 0; i < 10 && (m_since % 10) != p; i++) cycle(0, 0, 0);
  endtask

  task automatic clr_obs();
    clr_cnt   = 0;
    upd_cnt   = 0;
    clr_first = -1;
  endtask

  initial begin
    int k;
    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_idx   = '0;
    clr_obs();
    rel = 0;
    @(posedge CLK);
    #1;
    m_since  = 0;
    m_idx    = 2;
    m_active = 0;
    m_err    = 0;
    m_pend   = 2;
    m_t1     = 0;

    // reset held 3 cycles, then free run
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    rel = cyc;
    strobe_q.delete();
    chk("rst_alpha", coef_alpha, 32'h2000);
    idle(30);
    chk("rst_beta", coef_beta, 32'h6000);
    chk("rst_strobes", strobe_q.size(), 3);
    chk("rst_strobe0", strobe_q.size() > 0 ? strobe_q[0] : -1, 9);
    chk("rst_strobe1", strobe_q.size() > 1 ? strobe_q[1] : -1, 19);
    chk("rst_strobe2", strobe_q.size() > 2 ? strobe_q[2] : -1, 29);

    // basic change at ui_cnt=3
    wait_phase(3);
    clr_obs();
    t0c = cyc;
    cycle(0, 1, 5);
    idle(26);
    chk("b_flush_off", clr_first - t0c, 7);
    chk("b_flush_len", clr_cnt, 16);
    chk("b_upd_cnt", upd_cnt, 1);
    chk("b_alpha", coef_alpha, 32'h5000);
    chk("b_beta", coef_beta, 32'h3000);
    chk("b_ready", bus.cfg_ready, 1);

    // accept coincident with strobe
    wait_phase(9);
    clr_obs();
    t0c = cyc;
    k = int'($urandom_range(0, 7));
    cycle(0, 1, k);
    idle(32);
    chk("c_flush_off", clr_first - t0c, 11);
    chk("c_flush_len", clr_cnt, 16);
    chk("c_alpha", coef_alpha, k * 4096);

    // index 7 then out-of-range
    wait_free();
    cycle(0, 1, 7);
    wait_free();
    idle(2);
    chk("i_alpha7", coef_alpha, 32'h7000);
    cycle(0, 1, 8);
    chk("i_err", bus.cfg_err, 1);
    chk("i_busy", busy, 0);
    cycle(0, 0, 0);
    chk("i_err_pulse", bus.cfg_err, 0);
    chk("i_alpha_hold", coef_alpha, 32'h7000);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, int'($urandom_range(9, 15)));
      cycle(0, 0, 0);
    end

    // reset in flush cycle 5
    k = int'($urandom_range(3, 6));
    cycle(0, 1, k);
    for (int i = 0; i < 40 && !(m_active && cyc == m_t1 + 5); i++)
      cycle(0, 0, 0);
    chk("r_in_flush", filt_clr, 1);
    cycle(1, 0, 0);
    chk("r_clr", filt_clr, 0);
    chk("r_idx", att_idx, 2);
    chk("r_alpha", coef_alpha, 32'h2000);
    rel = cyc;
    strobe_q.delete();
    idle(12);
    chk("r_strobes", strobe_q.size(), 1);
    chk("r_strobe0", strobe_q.size() > 0 ? strobe_q[0] : -1, 9);

    // valid held: idx 1 then idx 6
    strobe_q.delete();
    clr_obs();
    for (int i = 0; i < 40; i++) cycle(0, 1, 1);
    for (int i = 0; i < 40; i++) cycle(0, 1, 6);
    chk("h_strobes", strobe_q.size(), 8);
    for (int i = 1; i < strobe_q.size(); i++)
      chk("h_period", strobe_q[i] - strobe_q[i-1], 10);
    wait_free();
    idle(2);
    chk("h_idx", att_idx, 6);

    // random traffic with rare resets
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) == 0,
            1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)));
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
